// File: rtl/crc32_pkg.sv
// rtl/crc32_pkg.sv - CRC-32 constants, checker FSM states and error-bit indices
package crc32_pkg;

  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_RES  = 2'd2
  } crc_chk_state_e;

  localparam int ERR_SHORT = 0;
  localparam int ERR_OVER  = 1;

endpackage

// File: rtl/crc32_chk_d32_if.sv
// rtl/crc32_chk_d32_if.sv - word stream in, frame result out, for the CRC-32 checker
interface crc32_chk_d32_if #(
  parameter int MAX_WORDS = 1024
);
  localparam int LW = $clog2(MAX_WORDS + 1);

  logic [31:0]   i_d;
  logic          i_d_vld;
  logic          i_d_last;
  logic          o_d_rdy;
  logic          o_res_vld;
  logic          i_res_rdy;
  logic          o_res_ok;
  logic [LW-1:0] o_res_len;
  logic [1:0]    o_res_err;

  modport master (
    output i_d, i_d_vld, i_d_last, i_res_rdy,
    input  o_d_rdy, o_res_vld, o_res_ok, o_res_len, o_res_err
  );

  modport slave (
    input  i_d, i_d_vld, i_d_last, i_res_rdy,
    output o_d_rdy, o_res_vld, o_res_ok, o_res_len, o_res_err
  );
endinterface

// File: rtl/crc32_d32_nxt.sv
// rtl/crc32_d32_nxt.sv - one 32-bit word of CRC-32 update, MSB first, no reflection
module crc32_d32_nxt
  import crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] d,
  output logic [31:0] crc_out
);

  logic [31:0] c;
  logic        fb;

  // Unrolled serial LFSR: bit 31 of the word enters first.
  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc32_chk_d32.sv
// rtl/crc32_chk_d32.sv - frame CRC-32 checker; CRC_CHK_STAT_EN adds good/bad frame counters
module crc32_chk_d32
  import crc32_pkg::*;
#(
  parameter int MAX_WORDS = 1024
) (
  input  logic           i_clk,
  input  logic           i_rst,
  crc32_chk_d32_if.slave bus
`ifdef CRC_CHK_STAT_EN
  ,
  output logic [15:0]    o_cnt_good,
  output logic [15:0]    o_cnt_bad
`endif
);

  localparam int            LW      = $clog2(MAX_WORDS + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_WORDS);

  crc_chk_state_e state, state_nxt;
  logic [31:0]    crc, crc_nxt;
  logic [LW-1:0]  len;
  logic           over;
  logic           accept;
  logic           res_vld;
  logic           res_done;
  logic [1:0]     err;

  crc32_d32_nxt u_nxt (
    .crc_in  (crc),
    .d       (bus.i_d),
    .crc_out (crc_nxt)
  );

  assign bus.o_d_rdy = (state != ST_RES);
  assign accept      = bus.i_d_vld & bus.o_d_rdy;
  assign res_vld     = (state == ST_RES);
  assign res_done    = res_vld & bus.i_res_rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = bus.i_d_last ? ST_RES : ST_RECV;
      ST_RECV: if (accept && bus.i_d_last) state_nxt = ST_RES;
      ST_RES:  if (bus.i_res_rdy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Once the length saturates, further words only raise the overlength flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crc  <= CRC_INIT;
      len  <= '0;
      over <= 1'b0;
    end else if (accept) begin
      crc <= crc_nxt;
      if (state == ST_IDLE) len <= LW'(1);
      else if (len == LEN_MAX) over <= 1'b1;
      else len <= len + LW'(1);
    end else if (res_done) begin
      crc  <= CRC_INIT;
      len  <= '0;
      over <= 1'b0;
    end
  end

  always_comb begin
    err            = 2'b00;
    err[ERR_SHORT] = (len == LW'(1));
    err[ERR_OVER]  = over;
  end

  assign bus.o_res_vld = res_vld;
  assign bus.o_res_ok  = res_vld && (crc == CRC_RESIDUE) && (err == 2'b00);
  assign bus.o_res_len = res_vld ? len : '0;
  assign bus.o_res_err = res_vld ? err : 2'b00;

`ifdef CRC_CHK_STAT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_good <= '0;
      o_cnt_bad  <= '0;
    end else if (res_done) begin
      if (bus.o_res_ok) begin
        if (o_cnt_good != 16'hFFFF) o_cnt_good <= o_cnt_good + 16'd1;
      end else begin
        if (o_cnt_bad != 16'hFFFF) o_cnt_bad <= o_cnt_bad + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crc32_chk_d32.sv
// tb/tb_crc32_chk_d32.sv - directed bench for crc32_chk_d32 (MAX_WORDS 1024 and 8); CRC_CHK_STAT_EN adds counter checks
module tb_crc32_chk_d32;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] d;
  logic        d_vld, d_last, res_rdy;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] fr[$];
  logic [31:0] saved[$];

  always #5 i_clk = ~i_clk;

  crc32_chk_d32_if #(.MAX_WORDS(1024)) bus ();
  crc32_chk_d32_if #(.MAX_WORDS(8))    bus8 ();

  assign bus.i_d        = d;
  assign bus.i_d_vld    = d_vld;
  assign bus.i_d_last   = d_last;
  assign bus.i_res_rdy  = res_rdy;
  assign bus8.i_d       = d;
  assign bus8.i_d_vld   = d_vld;
  assign bus8.i_d_last  = d_last;
  assign bus8.i_res_rdy = res_rdy;

`ifdef CRC_CHK_STAT_EN
  logic [15:0] cnt_good, cnt_bad, cnt_good8, cnt_bad8;
`endif

  crc32_chk_d32 #(.MAX_WORDS(1024)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
`ifdef CRC_CHK_STAT_EN
    ,
    .o_cnt_good (cnt_good),
    .o_cnt_bad  (cnt_bad)
`endif
  );

  crc32_chk_d32 #(.MAX_WORDS(8)) dut8 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus8.slave)
`ifdef CRC_CHK_STAT_EN
    ,
    .o_cnt_good (cnt_good8),
    .o_cnt_bad  (cnt_bad8)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Whole word folded into the register, then 32 shifts.
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c ^ w;
    for (int k = 0; k < 32; k++) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
    return r;
  endfunction

  task automatic build(input int n);
    logic [31:0] c;
    logic [31:0] w;
    c = 32'hFFFF_FFFF;
    fr.delete();
    for (int i = 0; i < n - 1; i++) begin
      w = $urandom;
      fr.push_back(w);
      c = crc_model(c, w);
    end
    fr.push_back(c);
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    int t;
    t = 0;
    d = w; d_vld = 1'b1; d_last = last;
    while (bus.o_d_rdy !== 1'b1 && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 50) check("rdy_timeout", 32'd0, 32'd1);
    @(negedge i_clk);
    d_vld = 1'b0; d_last = 1'b0;
  endtask

  // Every 7th word is preceded by an idle cycle carrying a stray last flag.
  task automatic send_frame();
    for (int i = 0; i < fr.size(); i++) begin
      if (i % 7 == 3) begin
        d = 32'hDEAD_BEEF; d_vld = 1'b0; d_last = 1'b1;
        @(negedge i_clk);
      end
      send(fr[i], i == fr.size() - 1);
    end
  endtask

  task automatic res_chk(input string tag, input logic ok, input int len, input logic [1:0] err);
    check({tag, "_vld"}, 32'(bus.o_res_vld), 32'd1);
    check({tag, "_ok"},  32'(bus.o_res_ok),  32'(ok));
    check({tag, "_len"}, 32'(bus.o_res_len), 32'(len));
    check({tag, "_err"}, 32'(bus.o_res_err), 32'(err));
  endtask

  task automatic res8_chk(input string tag, input logic ok, input int len, input logic [1:0] err);
    check({tag, "_vld"}, 32'(bus8.o_res_vld), 32'd1);
    check({tag, "_ok"},  32'(bus8.o_res_ok),  32'(ok));
    check({tag, "_len"}, 32'(bus8.o_res_len), 32'(len));
    check({tag, "_err"}, 32'(bus8.o_res_err), 32'(err));
  endtask

  task automatic handshake();
    res_rdy = 1'b1;
    @(negedge i_clk);
    res_rdy = 1'b0;
  endtask

  initial begin
    int vld_seen;
    void'($urandom(32'd1234));
    i_rst = 1'b1; d = '0; d_vld = 1'b0; d_last = 1'b0; res_rdy = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;

    check("rst_rdy", 32'(bus.o_d_rdy),   32'd1);
    check("rst_vld", 32'(bus.o_res_vld), 32'd0);
    check("rst_ok",  32'(bus.o_res_ok),  32'd0);
    check("rst_len", 32'(bus.o_res_len), 32'd0);
    check("rst_err", 32'(bus.o_res_err), 32'd0);

    // 100 data words + CRC
    build(101);
    saved = fr;
    send_frame();
    res_chk("good101", 1'b1, 101, 2'b00);
    check("good101_rdy", 32'(bus.o_d_rdy), 32'd0);
    res8_chk("over101", 1'b0, 8, 2'b10);
    handshake();
    check("post_hs_vld", 32'(bus.o_res_vld), 32'd0);
    check("post_hs_rdy", 32'(bus.o_d_rdy),   32'd1);

    // Same frame, bit 0 of word 50 flipped
    fr = saved;
    fr[50] = fr[50] ^ 32'd1;
    send_frame();
    res_chk("flip50", 1'b0, 101, 2'b00);
    handshake();

    // Single-word frame
    fr.delete();
    fr.push_back(32'h1234_5678);
    send_frame();
    res_chk("short", 1'b0, 1, 2'b01);
    res8_chk("short8", 1'b0, 1, 2'b01);
    handshake();

    // Overlength on the 8-word checker, normal on the wide one
    build(10);
    send_frame();
    res8_chk("over10", 1'b0, 8, 2'b10);
    res_chk("wide10", 1'b1, 10, 2'b00);
    handshake();

    // Exactly MAX_WORDS is still legal
    build(8);
    send_frame();
    res8_chk("exact8", 1'b1, 8, 2'b00);
    handshake();

    // Result held under back-pressure while the next word waits
    fr.delete();
    fr.push_back(32'h0BAD_F00D);
    send_frame();
    for (int k = 0; k < 5; k++) begin
      check("bp_rdy", 32'(bus.o_d_rdy),   32'd0);
      check("bp_vld", 32'(bus.o_res_vld), 32'd1);
      check("bp_len", 32'(bus.o_res_len), 32'd1);
      check("bp_err", 32'(bus.o_res_err), 32'd1);
      if (k == 0) begin
        d = 32'hCAFE_F00D; d_vld = 1'b1; d_last = 1'b1;
      end
      @(negedge i_clk);
    end
    handshake();
    check("bp_hs_vld", 32'(bus.o_res_vld), 32'd0);
    check("bp_hs_rdy", 32'(bus.o_d_rdy),   32'd1);
    @(negedge i_clk);
    d_vld = 1'b0; d_last = 1'b0;
    res_chk("bp_next", 1'b0, 1, 2'b01);
    handshake();

    // Reset in the middle of a frame
    build(6);
    for (int i = 0; i < 3; i++) send(fr[i], 1'b0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    vld_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.o_res_vld === 1'b1) vld_seen++;
      @(negedge i_clk);
    end
    check("midrst_novld", 32'(vld_seen), 32'd0);
    check("midrst_rdy", 32'(bus.o_d_rdy), 32'd1);
    build(5);
    send_frame();
    res_chk("after_rst", 1'b1, 5, 2'b00);
    handshake();

`ifdef CRC_CHK_STAT_EN
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("cnt_rst_good", 32'(cnt_good), 32'd0);
    check("cnt_rst_bad",  32'(cnt_bad),  32'd0);
    for (int f = 0; f < 5; f++) begin
      build(3);
      if (f == 1 || f == 3) fr[0] = fr[0] ^ 32'h8000_0000;
      send_frame();
      handshake();
    end
    check("cnt_good", 32'(cnt_good), 32'd3);
    check("cnt_bad",  32'(cnt_bad),  32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/crc32_chk_d32.md
CRC32_CHK_D32 -- requirements
Module: crc32_chk_d32

Interface
REQ-001 Parameter MAX_WORDS, default 1024: maximum words per frame, including the trailing CRC word.
REQ-002 Port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-003 Port i_rst, input, 1: reset, synchronous, active-high.
REQ-004 Port i_d, input, 32: frame word; the trailing word is the CRC produced by crc32_d32.
REQ-005 Port i_d_vld, input, 1: i_d valid.
REQ-006 Port i_d_last, input, 1: marks the CRC word (last word of the frame); qualified by i_d_vld.
REQ-007 Port o_d_rdy, output, 1: checker accepts a word when i_d_vld and o_d_rdy are both high.
REQ-008 Port o_res_vld, output, 1: frame result valid.
REQ-009 Port i_res_rdy, input, 1: result consumed when o_res_vld and i_res_rdy are both high.
REQ-010 Port o_res_ok, output, 1: residue zero, no length error.
REQ-011 Port o_res_len, output, $clog2(MAX_WORDS+1): words accepted, CRC word included, saturating at MAX_WORDS.
REQ-012 Port o_res_err, output, 2: bit0 short frame (1 word); bit1 overlength (>MAX_WORDS).
REQ-013 Ports o_cnt_good and o_cnt_bad, output, 16 each: present only under CRC_CHK_STAT_EN.

Function
REQ-014 CRC: polynomial 0x04C11DB7, 32-bit parallel update, MSB first, init 0xFFFFFFFF, no reflection, no final XOR; identical to crc32_d32.
REQ-015 FSM states: IDLE, RECV, RES.
REQ-016 IDLE: o_d_rdy=1, crc=init, len=0; an accepted word updates crc, sets len=1, goes to RECV; if i_d_last also set, goes to RES.
REQ-017 RECV: o_d_rdy=1; each accepted word updates crc, len+1 (saturating); accepted word with i_d_last goes to RES.
REQ-018 RES: o_d_rdy=0, o_res_vld=1, result fields stable until handshake; on i_res_rdy returns to IDLE with crc=init.
REQ-019 Latency: word with i_d_last accepted in cycle N gives o_res_vld=1 in cycle N+1.
REQ-020 o_res_ok=1 iff residue after the CRC word == 0x00000000 and o_res_err==0.
REQ-021 Short frame: len==1 sets err bit0 and o_res_ok=0, regardless of residue.
REQ-022 Overlength: accepted word while len==MAX_WORDS sets a sticky flag; CRC keeps updating until last; err bit1=1, o_res_ok=0.
REQ-023 i_d_vld low: no state change; gaps inside a frame are legal.
REQ-024 i_d_last without i_d_vld: ignored.
REQ-025 Back-to-back frames: first word of the next frame is accepted in the cycle after the result handshake, never earlier.

Reset
REQ-026 i_rst high at a clock edge: state=IDLE, crc=0xFFFFFFFF, len=0, err=0, o_res_vld=0, o_res_ok=0, o_res_len=0, o_res_err=0, o_d_rdy=1 from the next cycle.
REQ-027 Reset mid-frame or in RES discards the frame without producing a result.
REQ-028 Reset clears the statistics counters when present.

Configuration
REQ-029 Macro CRC_CHK_STAT_EN.
- Defined: o_cnt_good / o_cnt_bad increment on each result handshake with o_res_ok=1 / 0; saturate at 0xFFFF.
- Undefined: ports and counters absent; all other behaviour unchanged.

Structure
REQ-030 Package crc32_pkg holds:
- CRC_POLY, CRC_INIT, CRC_RESIDUE constants
- FSM state enum typedef
- error-bit index constants
REQ-031 One combinational sub-module crc32_d32_nxt (crc_in, d -> crc_out) holds the update equation; also reusable by crc32_d32.

Verification
REQ-032 100 random words, then the golden-model CRC as last word, i_res_rdy=1 -> o_res_vld one cycle later, o_res_ok=1, o_res_len=101, o_res_err=0.
REQ-033 Same frame with bit 0 of word 50 flipped -> o_res_ok=0, o_res_err=0, o_res_len=101.
REQ-034 Single word 0x12345678 with i_d_last -> o_res_err=2'b01, o_res_ok=0, o_res_len=1.
REQ-035 MAX_WORDS=8, 10-word frame with valid CRC -> o_res_err=2'b10, o_res_ok=0, o_res_len=8.
REQ-036 i_res_rdy held low 5 cycles -> o_d_rdy=0 and result stable for 5 cycles; next frame accepted only after the handshake; i_rst pulse mid-frame -> no o_res_vld, and the next valid frame passes.
REQ-037 CRC_CHK_STAT_EN defined, 3 good and 2 bad frames -> o_cnt_good=3, o_cnt_bad=2.
